// File: rtl/wb_pkg.sv
// Shared definitions for the writeback port arbiter slice.
//   REG_ADDR_W : architectural register index width
//   ZERO_REG   : x0, never written
//   wb_req_t   : one register-file write request at the default data width
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_XLEN    = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [WB_XLEN-1:0]    wd;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer holding mul/div results waiting for a free write-port cycle.
// Each entry carries a live bit; dead entries (x0 or killed by a younger
// pipeline write) still occupy a slot and drain without writing.
// Ports:
//   clk, rst            clock, async active-low reset
//   push, push_waddr/wd enqueue one entry (ignored when full)
//   pop                 dequeue the head (ignored when empty)
//   kill_en, kill_addr  clear live on every stored entry targeting kill_addr
//   head_*              head entry contents
//   full, empty, count  occupancy
//   live_vec, addr_vec  per-slot live bits and destinations
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  logic [REG_ADDR_W-1:0]                 push_waddr,
  input  logic [XLEN-1:0]                       push_wd,
  input  logic                                  pop,
  input  logic                                  kill_en,
  input  logic [REG_ADDR_W-1:0]                 kill_addr,
  output logic                                  head_live,
  output logic [REG_ADDR_W-1:0]                 head_waddr,
  output logic [XLEN-1:0]                       head_wd,
  output logic                                  full,
  output logic                                  empty,
  output logic [$clog2(DEPTH):0]                count,
  output logic [DEPTH-1:0]                      live_vec,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      addr_vec
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]                 rd_ptr;
  logic [PW-1:0]                 wr_ptr;
  logic [DEPTH-1:0]              live;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] waddr;
  logic [XLEN-1:0]               wd [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_live  = live[rd_ptr];
  assign head_waddr = waddr[rd_ptr];
  assign head_wd    = wd[rd_ptr];
  assign live_vec   = live;
  assign addr_vec   = waddr;

  // Kill first, then pop, then push: the pushed slot is never live beforehand
  // (not full), so the kill cannot touch the entry written on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      live   <= '0;
      waddr  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) wd[i] <= '0;
    end else begin
      if (kill_en) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (waddr[i] == kill_addr) live[i] <= 1'b0;
        end
      end
      if (pop_ok) begin
        live[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        live[wr_ptr]  <= (push_waddr != ZERO_REG);
        waddr[wr_ptr] <= push_waddr;
        wd[wr_ptr]    <= push_wd;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter. The in-order pipeline writeback has fixed
// priority; mul/div results are queued in wb_fifo and drain into idle cycles.
// A granted pipeline write kills older queued results to the same register.
// Optional macro WB_MD_BYPASS_EN: with an empty FIFO and no pipeline write,
// a valid mul/div result goes straight to the write port.
// Ports:
//   clk, rst                      clock, async active-low reset
//   pipe_we/waddr/wd              pipeline writeback
//   md_valid/ready/waddr/wd       mul/div result handshake
//   rf_we/waddr/wd                registered register-file write port
//   pending_mask                  destinations of live queued entries
//   fifo_count                    queue occupancy
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_we,
  input  logic [REG_ADDR_W-1:0]   pipe_waddr,
  input  logic [XLEN-1:0]         pipe_wd,
  input  logic                    md_valid,
  output logic                    md_ready,
  input  logic [REG_ADDR_W-1:0]   md_waddr,
  input  logic [XLEN-1:0]         md_wd,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [XLEN-1:0]         rf_wd,
  output logic [31:0]             pending_mask,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  logic                              pipe_grant;
  logic                              bypass;
  logic                              push;
  logic                              pop;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic                              head_live;
  logic [REG_ADDR_W-1:0]             head_waddr;
  logic [XLEN-1:0]                   head_wd;
  logic [DEPTH-1:0]                  live_vec;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  addr_vec;

  assign pipe_grant = pipe_we && (pipe_waddr != ZERO_REG);

`ifdef WB_MD_BYPASS_EN
  assign bypass = md_valid && fifo_empty && !pipe_grant;
`else
  assign bypass = 1'b0;
`endif

  assign md_ready = !fifo_full;
  assign push     = md_valid && !fifo_full && !bypass;
  assign pop      = !pipe_grant && !bypass && !fifo_empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_waddr (md_waddr),
    .push_wd    (md_wd),
    .pop        (pop),
    .kill_en    (pipe_grant),
    .kill_addr  (pipe_waddr),
    .head_live  (head_live),
    .head_waddr (head_waddr),
    .head_wd    (head_wd),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .live_vec   (live_vec),
    .addr_vec   (addr_vec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wd    <= '0;
    end else if (pipe_grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= pipe_waddr;
      rf_wd    <= pipe_wd;
    end else if (bypass) begin
      rf_we    <= (md_waddr != ZERO_REG);
      rf_waddr <= md_waddr;
      rf_wd    <= md_wd;
    end else if (pop) begin
      rf_we    <= head_live;
      rf_waddr <= head_waddr;
      rf_wd    <= head_wd;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Live entries never target x0; bit 0 is forced clear regardless.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_vec[i]) pending_mask[addr_vec[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule
